// File: rtl/cam_sync_capture.sv
// cam_sync_capture: synchronises CHANNELS asynchronous camera sync inputs into
// the clk domain, generates per-channel edge pulses with a selectable edge mode,
// and runs a VSYNC-gated frame-capture FSM that frames an N-frame or continuous
// capture window.
//
// Ports:
//   clk            system clock, rising edge
//   in_reset       asynchronous active-low reset
//   async_in       raw sync inputs (ch0 = VSYNC, ch1 = HREF)
//   edge_mode      per-channel edge select [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
//   sync_out       synchronised copy of async_in
//   edge_pulse     one-cycle pulse on the selected edge(s) of sync_out
//   capture_req    level capture request
//   num_frames     frames to capture (0 = continuous), latched on IDLE->ARMED
//   capture_busy   high outside IDLE
//   capture_active high while a frame is being captured
//   capture_done   one-cycle pulse on completion or abort
//   frame_count    frames completed in the current or last capture
module cam_sync_capture #(
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FRAME_CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     in_reset,
   input  logic [CHANNELS-1:0]      async_in,
   input  logic [2*CHANNELS-1:0]    edge_mode,
   output logic [CHANNELS-1:0]      sync_out,
   output logic [CHANNELS-1:0]      edge_pulse,
   input  logic                     capture_req,
   input  logic [FRAME_CNT_W-1:0]   num_frames,
   output logic                     capture_busy,
   output logic                     capture_active,
   output logic                     capture_done,
   output logic [FRAME_CNT_W-1:0]   frame_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_CAPTURE = 3'd2,
      S_GAP     = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [FRAME_CNT_W-1:0] CNT_MAX = '1;

   logic [CHANNELS-1:0]    sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0]    prev;
   logic [CHANNELS-1:0]    rise;
   logic [CHANNELS-1:0]    fall;
   logic                   vs_rise;
   logic                   vs_fall;

   state_t                 state;
   state_t                 next_state;
   logic [FRAME_CNT_W-1:0] n_lat;
   logic [FRAME_CNT_W-1:0] n_lat_d;
   logic [FRAME_CNT_W-1:0] count_d;
   logic [FRAME_CNT_W-1:0] count_inc;
   logic                   busy_d;
   logic                   active_d;
   logic                   done_d;

   // Synchroniser chain; prev holds last cycle's synchronised value
   always_ff @(posedge clk or negedge in_reset) begin
      if (!in_reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         prev <= '0;
      end else begin
         sync_q[0] <= async_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_out & ~prev;
   assign fall     = ~sync_out & prev;

   // FSM edges come straight from channel 0, independent of edge_mode
   assign vs_rise  = rise[0];
   assign vs_fall  = fall[0];

   // Per-channel edge select
   always_comb begin
      edge_pulse = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         edge_pulse[i] = (edge_mode[2*i] & rise[i]) | (edge_mode[2*i+1] & fall[i]);
      end
   end

   // Saturating frame counter increment
   assign count_inc = (frame_count == CNT_MAX) ? frame_count : frame_count + FRAME_CNT_W'(1);

   // State register plus registered outputs
   always_ff @(posedge clk or negedge in_reset) begin
      if (!in_reset) begin
         state          <= S_IDLE;
         n_lat          <= '0;
         frame_count    <= '0;
         capture_busy   <= 1'b0;
         capture_active <= 1'b0;
         capture_done   <= 1'b0;
      end else begin
         state          <= next_state;
         n_lat          <= n_lat_d;
         frame_count    <= count_d;
         capture_busy   <= busy_d;
         capture_active <= active_d;
         capture_done   <= done_d;
      end
   end

   // Next-state logic; a frame in progress always runs to its vs_rise
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (capture_req) next_state = S_ARMED;
         end
         S_ARMED: begin
            if (!capture_req)  next_state = S_IDLE;
            else if (vs_fall)  next_state = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (vs_rise) begin
               if (((n_lat != '0) && (count_inc == n_lat)) || !capture_req)
                  next_state = S_DONE;
               else
                  next_state = S_GAP;
            end
         end
         S_GAP: begin
            if (!capture_req)  next_state = S_DONE;
            else if (vs_fall)  next_state = S_CAPTURE;
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Output/datapath next values; an ARMED abort pulses done on the way to IDLE
   always_comb begin
      busy_d   = (next_state != S_IDLE);
      active_d = (next_state == S_CAPTURE);
      done_d   = (next_state == S_DONE) || ((state == S_ARMED) && !capture_req);
      n_lat_d  = n_lat;
      count_d  = frame_count;
      if ((state == S_IDLE) && capture_req) begin
         n_lat_d = num_frames;
         count_d = '0;
      end else if ((state == S_CAPTURE) && vs_rise) begin
         count_d = count_inc;
      end
   end

endmodule

// File: tb/tb_cam_sync_capture.sv
// Randomised scoreboard bench for cam_sync_capture: a stimulus process drives
// inputs, advances a behavioural model and queues the expected outputs; a
// monitor pops and compares each cycle on the falling edge.
module tb_cam_sync_capture;

   localparam int unsigned CH     = 2;
   localparam int unsigned SS     = 2;
   localparam int unsigned FW     = 3;
   localparam int          CYCLES = 6000;

   logic          clk = 1'b0;
   logic          in_reset;
   logic [CH-1:0] async_in;
   logic [2*CH-1:0] edge_mode;
   logic [CH-1:0] sync_out;
   logic [CH-1:0] edge_pulse;
   logic          capture_req;
   logic [FW-1:0] num_frames;
   logic          capture_busy;
   logic          capture_active;
   logic          capture_done;
   logic [FW-1:0] frame_count;

   always #5 clk = ~clk;

   cam_sync_capture #(
      .CHANNELS    (CH),
      .SYNC_STAGES (SS),
      .FRAME_CNT_W (FW)
   ) dut (
      .clk            (clk),
      .in_reset       (in_reset),
      .async_in       (async_in),
      .edge_mode      (edge_mode),
      .sync_out       (sync_out),
      .edge_pulse     (edge_pulse),
      .capture_req    (capture_req),
      .num_frames     (num_frames),
      .capture_busy   (capture_busy),
      .capture_active (capture_active),
      .capture_done   (capture_done),
      .frame_count    (frame_count)
   );

   typedef struct packed {
      logic [CH-1:0] sync;
      logic [CH-1:0] edg;
      logic          busy;
      logic          active;
      logic          done;
      logic [FW-1:0] count;
   } snap_t;

   snap_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   // Reference model: delay line of samples plus capture-session flags
   logic [CH-1:0] m_hist[$];
   logic [CH-1:0] m_sync;
   logic [CH-1:0] m_prev;
   bit            m_busy, m_started, m_in_frame, m_closing, m_abort_pulse;
   int            m_count, m_target;

   function automatic void model_reset();
      m_hist.delete();
      for (int i = 0; i < int'(SS); i++) m_hist.push_back('0);
      m_sync        = '0;
      m_prev        = '0;
      m_busy        = 0;
      m_started     = 0;
      m_in_frame    = 0;
      m_closing     = 0;
      m_abort_pulse = 0;
      m_count       = 0;
      m_target      = 0;
   endfunction

   function automatic void model_edge(input logic [CH-1:0] a, input bit req, input int nf);
      bit vsf;
      bit vsr;
      vsf = !m_sync[0] && m_prev[0];
      vsr = m_sync[0] && !m_prev[0];
      m_abort_pulse = 0;
      if (m_closing) begin
         m_closing = 0;
         m_busy    = 0;
      end else if (!m_busy) begin
         if (req) begin
            m_busy     = 1;
            m_started  = 0;
            m_in_frame = 0;
            m_count    = 0;
            m_target   = nf;
         end
      end else if (!m_started) begin
         if (!req) begin
            m_busy        = 0;
            m_abort_pulse = 1;
         end else if (vsf) begin
            m_started  = 1;
            m_in_frame = 1;
         end
      end else if (m_in_frame) begin
         if (vsr) begin
            if (m_count < (1 << FW) - 1) m_count++;
            m_in_frame = 0;
            if ((m_target != 0 && m_count == m_target) || !req) m_closing = 1;
         end
      end else begin
         if (!req)     m_closing  = 1;
         else if (vsf) m_in_frame = 1;
      end
      m_prev = m_sync;
      m_hist.push_back(a);
      void'(m_hist.pop_front());
      m_sync = m_hist[0];
   endfunction

   function automatic snap_t model_snap(input logic [2*CH-1:0] mode);
      snap_t s;
      s.sync = m_sync;
      for (int i = 0; i < int'(CH); i++) begin
         bit r;
         bit f;
         int md;
         r  = m_sync[i] && !m_prev[i];
         f  = !m_sync[i] && m_prev[i];
         md = int'(mode[2*i +: 2]);
         s.edg[i] = ((md == 1 || md == 3) && r) || ((md == 2 || md == 3) && f);
      end
      s.busy   = m_busy;
      s.active = m_in_frame;
      s.done   = m_closing || m_abort_pulse;
      s.count  = FW'(m_count);
      return s;
   endfunction

   // Stimulus: advance model on each edge, then drive new inputs and queue expectation
   initial begin
      int rst_hold;
      rst_hold    = 0;
      in_reset    = 1'b0;
      async_in    = '0;
      edge_mode   = 4'b0111;
      capture_req = 1'b0;
      num_frames  = '0;
      model_reset();
      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         @(posedge clk);
         if (in_reset) model_edge(async_in, capture_req, int'(num_frames));
         #1;
         if (cyc < 3) begin
            in_reset = 1'b0;
         end else if (!in_reset) begin
            if (rst_hold > 0) rst_hold--;
            else in_reset = 1'b1;
         end else if ($urandom_range(0, 699) == 0) begin
            in_reset = 1'b0;
            rst_hold = int'($urandom_range(0, 2));
         end
         if (!in_reset && $urandom_range(0, 1) == 0) async_in[0] = 1'b1;
         else if ($urandom_range(0, 9) == 0)          async_in[0] = ~async_in[0];
         if ($urandom_range(0, 2) == 0) async_in[1] = ~async_in[1];
         if ($urandom_range(0, 49) == 0) edge_mode = 4'($urandom_range(0, 15));
         if (capture_req) begin
            if ($urandom_range(0, 149) == 0) capture_req = 1'b0;
         end else if ($urandom_range(0, 5) == 0) begin
            capture_req = 1'b1;
         end
         if ($urandom_range(0, 9) < 3) num_frames = '0;
         else num_frames = FW'($urandom_range(1, (1 << FW) - 1));
         if (!in_reset) model_reset();
         exp_q.push_back(model_snap(edge_mode));
      end
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Monitor: compare DUT outputs against the queued expectation each cycle
   initial begin
      snap_t e;
      snap_t a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{sync: sync_out, edg: edge_pulse, busy: capture_busy,
                  active: capture_active, done: capture_done, count: frame_count};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs t=%0t: got sync=%b edge=%b busy=%b active=%b done=%b count=%0d; required sync=%b edge=%b busy=%b active=%b done=%b count=%0d",
                        $time, a.sync, a.edg, a.busy, a.active, a.done, a.count,
                        e.sync, e.edg, e.busy, e.active, e.done, e.count);
            end
         end
      end
   end

endmodule
